// File: rtl/tx_pkg.sv
// Shared types and default sizing for the buffered serial transmitter.
package tx_pkg;
    localparam int TX_DATA_WIDTH = 8;
    localparam int TX_ADDR_WIDTH = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        LOAD     = 3'd2,
        SEND     = 3'd3,
        DONE     = 3'd4
    } state_e;
endpackage

// File: rtl/tx_ram.sv
// Small host-loaded byte buffer: synchronous write, combinational read.
// Contents are deliberately not reset; the transmitter only reads after a host load.
module tx_ram
    import tx_pkg::*;
#(
    parameter int DATA_WIDTH = TX_DATA_WIDTH,
    parameter int ADDR_WIDTH = TX_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/tx.sv
// Buffered LSB-first serialiser: start -> first tx_valid in 3 cycles, each byte gated by rx_ready
// sampled only between bytes; a started byte always completes all DATA_WIDTH bits.
module tx
    import tx_pkg::*;
#(
    parameter int DATA_WIDTH = TX_DATA_WIDTH,
    parameter int ADDR_WIDTH = TX_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  start,
    input  logic                  rx_ready,
    output logic                  tx_valid,
    output logic                  tx_data,
    output logic                  tx_busy,
    output logic                  tx_finish
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  last_bit;
    logic                  ram_we;

    // Host writes are only accepted while idle so an in-flight burst sees a stable buffer.
    assign ram_we   = ld_we && (state_q == IDLE);
    assign last_bit = (cnt_q == LAST_BIT);

    tx_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i    (clk),
        .wr_en_i  (ram_we),
        .wr_addr_i(ld_addr),
        .wr_data_i(ld_data),
        .rd_addr_i(addr_q),
        .rd_data_o(rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = WAIT_RDY;
            WAIT_RDY: if (rx_ready) state_d = LOAD;
            LOAD:     state_d = SEND;
            SEND:     if (last_bit) state_d = (addr_q == LAST_ADDR) ? DONE : WAIT_RDY;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            LOAD: begin
                shift_d = rd_data;
                cnt_d   = '0;
            end
            SEND: begin
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit && (addr_q != LAST_ADDR)) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            DONE:    addr_d = '0;
            default: ;
        endcase
    end

    // Outputs decode state only, so no input reaches them combinationally.
    always_comb begin
        tx_valid  = (state_q == SEND);
        tx_data   = (state_q == SEND) & shift_q[0];
        tx_busy   = (state_q != IDLE);
        tx_finish = (state_q == DONE);
    end
endmodule

// File: tb/tb_tx.sv
// Bench for tx: reference is the expected LSB-first bit stream of the buffer plus cycle-timing rules.
module tb_tx;
    logic       clk;
    logic       rst_n;
    logic       ld_we;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic       start;
    logic       rx_ready;
    logic       tx_valid;
    logic       tx_data;
    logic       tx_busy;
    logic       tx_finish;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mem_m [4];
    logic       obs_bits [$];
    int         runs [$];
    int         run_len    = 0;
    int         first_vld  = -1;
    int         finish_cnt = 0;
    int         finish_cyc = -1;

    tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_we    (ld_we),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .start    (start),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_finish(tx_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (tx_valid) begin
                obs_bits.push_back(tx_data);
                if (first_vld < 0) first_vld = cyc;
                run_len++;
            end else if (run_len > 0) begin
                runs.push_back(run_len);
                run_len = 0;
            end
            if (tx_finish) begin
                finish_cnt++;
                finish_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        obs_bits.delete();
        runs.delete();
        run_len    = 0;
        first_vld  = -1;
        finish_cnt = 0;
        finish_cyc = -1;
    endtask

    task automatic write_buf(input int a, input logic [7:0] d);
        ld_we   = 1'b1;
        ld_addr = 2'(a);
        ld_data = d;
        step();
        ld_we   = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic kick(output int s);
        start = 1'b1;
        s     = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        for (int i = 0; i < budget && finish_cnt == 0; i++) step();
        repeat (3) step();
    endtask

    function automatic logic [7:0] byte_at(input int b);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b * 8 + k < obs_bits.size()) v[k] = obs_bits[b * 8 + k];
            else v[k] = ~mem_m[b][k];
        end
        return v;
    endfunction

    function automatic int bad_runs();
        int n;
        n = 0;
        foreach (runs[i]) if (runs[i] != 8) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", tx_valid); end
        total++; if (tx_data !== 1'b0) begin bad++; $display("FAIL reset_data got=%b want=0", tx_data); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
        total++; if (tx_finish !== 1'b0) begin bad++; $display("FAIL reset_finish got=%b want=0", tx_finish); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int s;
        write_buf(0, 8'hA5);
        write_buf(1, 8'h3C);
        write_buf(2, 8'hFF);
        write_buf(3, 8'h00);
        rx_ready = 1'b1;
        clear_mon();
        kick(s);
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", tx_busy); end
        wait_finish(100);
        total++; if (first_vld != s + 3) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", first_vld - s, 3); end
        total++; if (finish_cyc != s + 41) begin bad++; $display("FAIL basic_finish_time got=%0d want=%0d", finish_cyc - s - 1, 40); end
        total++; if (finish_cnt != 1) begin bad++; $display("FAIL basic_finish_cnt got=%0d want=1", finish_cnt); end
        total++; if (obs_bits.size() != 32) begin bad++; $display("FAIL basic_bits got=%0d want=32", obs_bits.size()); end
        for (int b = 0; b < 4; b++) begin
            total++;
            if (byte_at(b) !== mem_m[b]) begin bad++; $display("FAIL basic_byte%0d got=%h want=%h", b, byte_at(b), mem_m[b]); end
        end
        total++; if (runs.size() != 4 || bad_runs() != 0) begin bad++; $display("FAIL basic_runs got=%0d runs,%0d bad want=4,0", runs.size(), bad_runs()); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", tx_busy); end
    endtask

    task automatic test_stall();
        int s;
        int r;
        rx_ready = 1'b0;
        clear_mon();
        kick(s);
        repeat (10) step();
        total++; if (obs_bits.size() != 0 || tx_busy !== 1'b1) begin bad++; $display("FAIL stall_hold got=%0d bits busy=%b want=0 bits busy=1", obs_bits.size(), tx_busy); end
        r = cyc;
        rx_ready = 1'b1;
        wait_finish(100);
        total++; if (first_vld != r + 2) begin bad++; $display("FAIL stall_latency got=%0d want=%0d", first_vld - r, 2); end
        total++; if (finish_cyc != r + 40) begin bad++; $display("FAIL stall_finish_time got=%0d want=%0d", finish_cyc - r, 40); end
        for (int b = 0; b < 4; b++) begin
            total++;
            if (byte_at(b) !== mem_m[b]) begin bad++; $display("FAIL stall_byte%0d got=%h want=%h", b, byte_at(b), mem_m[b]); end
        end
    endtask

    task automatic test_ready_drop();
        int s;
        int r;
        rx_ready = 1'b1;
        clear_mon();
        kick(s);
        while (cyc < s + 5) step();
        rx_ready = 1'b0;
        while (cyc < s + 20) step();
        total++; if (obs_bits.size() != 8) begin bad++; $display("FAIL drop_first_byte got=%0d bits want=8", obs_bits.size()); end
        total++; if (tx_valid !== 1'b0 || tx_busy !== 1'b1) begin bad++; $display("FAIL drop_waiting got=valid %b busy %b want=valid 0 busy 1", tx_valid, tx_busy); end
        r = cyc;
        rx_ready = 1'b1;
        wait_finish(100);
        total++; if (finish_cyc != r + 30) begin bad++; $display("FAIL drop_finish_time got=%0d want=%0d", finish_cyc - r, 30); end
        total++; if (runs.size() != 4 || bad_runs() != 0) begin bad++; $display("FAIL drop_runs got=%0d runs,%0d bad want=4,0", runs.size(), bad_runs()); end
        for (int b = 0; b < 4; b++) begin
            total++;
            if (byte_at(b) !== mem_m[b]) begin bad++; $display("FAIL drop_byte%0d got=%h want=%h", b, byte_at(b), mem_m[b]); end
        end
    endtask

    task automatic test_ld_ignored();
        int s;
        rx_ready = 1'b1;
        clear_mon();
        kick(s);
        while (cyc < s + 5) step();
        ld_we   = 1'b1;
        ld_addr = 2'd0;
        ld_data = 8'h11;
        step();
        ld_we = 1'b0;
        wait_finish(100);
        clear_mon();
        kick(s);
        wait_finish(100);
        total++; if (byte_at(0) !== 8'hA5) begin bad++; $display("FAIL ld_ignored_byte0 got=%h want=a5", byte_at(0)); end
        total++; if (finish_cnt != 1) begin bad++; $display("FAIL ld_ignored_finish got=%0d want=1", finish_cnt); end
    endtask

    task automatic test_start_mid();
        int s;
        rx_ready = 1'b1;
        clear_mon();
        kick(s);
        while (cyc < s + 15) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_finish(100);
        repeat (20) step();
        total++; if (finish_cnt != 1) begin bad++; $display("FAIL start_mid_finish got=%0d want=1", finish_cnt); end
        total++; if (obs_bits.size() != 32 || tx_busy !== 1'b0) begin bad++; $display("FAIL start_mid_bits got=%0d busy=%b want=32 busy=0", obs_bits.size(), tx_busy); end
    endtask

    task automatic test_reset_mid();
        int s;
        rx_ready = 1'b1;
        clear_mon();
        kick(s);
        while (cyc < s + 17) step();
        total++; if (tx_valid !== 1'b1 || obs_bits.size() != 12) begin bad++; $display("FAIL rstmid_pos got=valid %b bits %0d want=valid 1 bits 12", tx_valid, obs_bits.size()); end
        #1 rst_n = 1'b0;
        #1;
        total++; if ({tx_valid, tx_data, tx_busy, tx_finish} !== 4'b0000) begin bad++; $display("FAIL rstmid_async got=%b want=0000", {tx_valid, tx_data, tx_busy, tx_finish}); end
        step();
        step();
        rst_n = 1'b1;
        clear_mon();
        repeat (10) step();
        total++; if (obs_bits.size() != 0 || finish_cnt != 0 || tx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=bits %0d fin %0d busy %b want=0 0 0", obs_bits.size(), finish_cnt, tx_busy); end
        clear_mon();
        kick(s);
        wait_finish(100);
        total++; if (first_vld != s + 3 || finish_cyc != s + 41) begin bad++; $display("FAIL rstmid_restart_time got=%0d,%0d want=3,41", first_vld - s, finish_cyc - s); end
        for (int b = 0; b < 4; b++) begin
            total++;
            if (byte_at(b) !== mem_m[b]) begin bad++; $display("FAIL rstmid_byte%0d got=%h want=%h", b, byte_at(b), mem_m[b]); end
        end
    endtask

    task automatic test_random();
        int s;
        logic [7:0] d;
        for (int it = 0; it < 6; it++) begin
            for (int a = 1; a < 4; a++) write_buf(a, 8'($urandom_range(0, 255)));
            d = 8'($urandom_range(0, 255));
            clear_mon();
            ld_we   = 1'b1;
            ld_addr = 2'd0;
            ld_data = d;
            start   = 1'b1;
            s       = cyc;
            step();
            ld_we = 1'b0;
            start = 1'b0;
            mem_m[0] = d;
            for (int i = 0; i < 400 && finish_cnt == 0; i++) begin
                rx_ready = ($urandom_range(0, 2) != 0);
                step();
            end
            repeat (3) step();
            total++; if (finish_cnt != 1) begin bad++; $display("FAIL rand%0d_finish got=%0d want=1", it, finish_cnt); end
            total++; if (runs.size() != 4 || bad_runs() != 0) begin bad++; $display("FAIL rand%0d_runs got=%0d runs,%0d bad want=4,0", it, runs.size(), bad_runs()); end
            for (int b = 0; b < 4; b++) begin
                total++;
                if (byte_at(b) !== mem_m[b]) begin bad++; $display("FAIL rand%0d_byte%0d got=%h want=%h", it, b, byte_at(b), mem_m[b]); end
            end
        end
    endtask

    initial begin
        ld_we    = 1'b0;
        ld_addr  = 2'd0;
        ld_data  = 8'h00;
        start    = 1'b0;
        rx_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_ready_drop();
        test_ld_ignored();
        test_start_mid();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx.md
TX -- requirements
Module: tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the byte width of each buffer entry and the serial frame length.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, giving the buffer address width (4 entries).
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port ld_we, input, 1: buffer write strobe from the host.
REQ-006 Port ld_addr, input, ADDR_WIDTH: buffer write address.
REQ-007 Port ld_data, input, DATA_WIDTH: buffer write data.
REQ-008 Port start, input, 1: single-cycle request to transmit the whole buffer.
REQ-009 Port rx_ready, input, 1: receiver ready for the next byte.
REQ-010 Port tx_valid, output, 1: high on every cycle a serial bit is driven.
REQ-011 Port tx_data, output, 1: serial data bit, LSB first.
REQ-012 Port tx_busy, output, 1: high whenever the FSM is not IDLE.
REQ-013 Port tx_finish, output, 1: one-cycle pulse after the last byte is sent.

Function
REQ-014 FSM states SHALL be IDLE, WAIT_RDY, LOAD, SEND and DONE.
REQ-015 IDLE: ld_we=1 writes ld_data to buffer[ld_addr] at the clock edge; start=1 moves to WAIT_RDY.
REQ-016 ld_we outside IDLE SHALL be ignored, and buffer contents SHALL stay unchanged.
REQ-017 start outside IDLE SHALL be ignored; start and ld_we in the same IDLE cycle SHALL both take effect.
REQ-018 WAIT_RDY: stay while rx_ready=0; move to LOAD on the first cycle rx_ready=1.
REQ-019 LOAD (1 cycle): shift register SHALL load buffer[addr] and bit counter SHALL clear to 0; tx_valid=0.
REQ-020 SEND: for exactly DATA_WIDTH consecutive cycles, tx_valid=1 and tx_data=shift_reg[0].
REQ-021 SEND: on each cycle the shift register SHALL shift right by one and the bit counter SHALL increment.
REQ-022 Bit k of the byte SHALL appear on tx_data in the k-th SEND cycle, k=0..DATA_WIDTH-1.
REQ-023 Bit counter width SHALL be $clog2(DATA_WIDTH); the last bit is detected at count DATA_WIDTH-1, with no wrap before it.
REQ-024 After the last bit, if addr != 2**ADDR_WIDTH-1, addr SHALL increment (modulo) and the FSM SHALL return to WAIT_RDY.
REQ-025 After the last bit, if addr == 2**ADDR_WIDTH-1, the FSM SHALL move to DONE.
REQ-026 rx_ready deasserting during LOAD or SEND SHALL NOT interrupt the byte; it is sampled only in WAIT_RDY.
REQ-027 DONE (1 cycle): tx_finish=1 and addr SHALL clear to 0; next state IDLE.
REQ-028 tx_valid and tx_finish SHALL be registered or decoded from state only, with no combinational path from any input.
REQ-029 Latency from start (rx_ready held 1) to the first tx_valid SHALL be 3 cycles (IDLE->WAIT_RDY->LOAD->SEND).
REQ-030 A full 4-byte burst with rx_ready held 1 SHALL take 4*(DATA_WIDTH+2) cycles from WAIT_RDY entry to DONE.

Reset
REQ-031 rst_n low SHALL immediately force: state=IDLE, addr=0, bit counter=0, shift register=0, tx_valid=0, tx_data=0, tx_busy=0, tx_finish=0.
REQ-032 Reset mid-SEND SHALL abort the frame with no further tx_valid until a new start.
REQ-033 Buffer storage SHALL NOT be reset; its contents are undefined until written.

Structure
REQ-034 A shared package tx_pkg SHALL hold the state enum type and the DATA_WIDTH/ADDR_WIDTH defaults.
REQ-035 The buffer SHALL be a sub-module tx_ram (parameters DATA_WIDTH, ADDR_WIDTH; write port from ld_*; read port addressed by addr).
REQ-036 Any tx_ram read latency SHALL be absorbed in LOAD without changing REQ-029.

Verification
REQ-037 Load 0xA5,0x3C,0xFF,0x00 at 0..3, start, rx_ready=1 -> serial 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0 ...; tx_finish exactly once, 40 cycles after WAIT_RDY entry.
REQ-038 rx_ready=0 for 10 cycles after start, then 1 -> tx_valid stays 0 for those 10 cycles, then the frame proceeds per REQ-029.
REQ-039 rx_ready dropped on the 3rd SEND cycle of byte 1 -> byte 1 completes all 8 bits; byte 2 waits in WAIT_RDY until rx_ready=1.
REQ-040 ld_we with ld_addr=0, ld_data=0x11 during SEND -> buffer[0] unchanged; re-sent data is still 0xA5.
REQ-041 rst_n low on the 5th SEND bit of byte 2 -> all outputs 0 asynchronously; a new start restarts from addr 0.
REQ-042 start pulsed during a burst -> ignored; exactly one tx_finish per burst.
